// File: rtl/rx_pkt_pkg.sv
// Shared definitions for the UART receive packet parser.
// Holds the parser state encoding, error codes and the default header byte.
// Also provides the modulo-256 checksum step used when accumulating bytes.
package rx_pkt_pkg;

  // Parser states; HOLD keeps an accepted packet until the host acknowledges it.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  // Err_Code values; the code of the most recent rejection is kept.
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CSUM = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Start-of-packet marker used unless the instance overrides it.
  localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;

  // One checksum step: 8-bit add with the carry dropped.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/rx_pkt_buffer.sv
// Payload store: 2**AW x 8 register file, one synchronous write, one registered read.
// Latency: Rd_Data follows rd_addr by one clock; writes land on the clock edge.
// No backpressure; the storage array itself is not reset, only the read register.
module rx_pkt_buffer #(
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  // Sized to the full address space so any rd_addr indexes a real entry.
  localparam int DEPTH = 2 ** AW;

  logic [7:0] mem [DEPTH];

  // Storage write; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, cleared by reset so the output starts at zero.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_data <= 8'd0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/rx_packet_parser.sv
// Frames UART bytes into header/length/payload/checksum packets and buffers good payloads.
// Latency: Pkt_Valid rises the cycle after the checksum byte; Rd_Data is one cycle behind Rd_Addr.
// Backpressure: RX_En_Sig drops while a packet is held and returns the cycle after Pkt_Ack.
module rx_packet_parser
  import rx_pkt_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 500000,
  parameter int         LW          = $clog2(MAX_LEN + 1),
  parameter int         AW          = $clog2(MAX_LEN)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          RX_Done_Sig,
  input  logic [7:0]    RX_Data,
  output logic          RX_En_Sig,
  output logic          Pkt_Valid,
  output logic [LW-1:0] Pkt_Len,
  input  logic [AW-1:0] Rd_Addr,
  output logic [7:0]    Rd_Data,
  input  logic          Pkt_Ack,
  output logic          Err_Sig,
  output logic [1:0]    Err_Code
);

  // Inter-byte timer is wide enough to reach TIMEOUT_CYC-1.
  localparam int            TW        = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  state_t        state;
  logic [7:0]    acc;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_nxt;
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic          len_bad;
  logic          buf_wr;

  // Next payload index and the decisions that depend only on current inputs.
  always_comb begin
    cnt_nxt = cnt + LW'(1);
    tmo_hit = (tmo == TMO_LAST);
    len_bad = (RX_Data == 8'd0) || (RX_Data > MAX_LEN_B);
  end

  // Payload bytes go straight into the buffer; HOLD never writes, so the held packet is frozen.
  assign buf_wr = (state == PAYLOAD) && RX_Done_Sig;

  rx_pkt_buffer #(
    .AW (AW)
  ) u_buffer (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .wr_en   (buf_wr),
    .wr_addr (cnt[AW-1:0]),
    .wr_data (RX_Data),
    .rd_addr (Rd_Addr),
    .rd_data (Rd_Data)
  );

  // Packet framing FSM with registered status outputs and the inter-byte timeout.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      acc       <= 8'd0;
      cnt       <= '0;
      tmo       <= '0;
      Pkt_Len   <= '0;
      Pkt_Valid <= 1'b0;
      RX_En_Sig <= 1'b1;
      Err_Sig   <= 1'b0;
      Err_Code  <= ERR_NONE;
    end else begin
      // Error strobe is a single-cycle pulse unless re-asserted below.
      Err_Sig <= 1'b0;

      case (state)
        IDLE: begin
          tmo <= '0;
          // Anything other than the header is line noise and dropped silently.
          if (RX_Done_Sig && (RX_Data == HDR_BYTE)) begin
            state <= LEN;
          end
        end

        LEN: begin
          if (RX_Done_Sig) begin
            tmo <= '0;
            if (len_bad) begin
              Err_Sig  <= 1'b1;
              Err_Code <= ERR_LEN;
              state    <= IDLE;
            end else begin
              Pkt_Len <= RX_Data[LW-1:0];
              cnt     <= '0;
              acc     <= RX_Data;
              state   <= PAYLOAD;
            end
          end else if (tmo_hit) begin
            tmo      <= '0;
            Err_Sig  <= 1'b1;
            Err_Code <= ERR_TMO;
            state    <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        PAYLOAD: begin
          // A header value here is just data; there is no resynchronisation.
          if (RX_Done_Sig) begin
            tmo <= '0;
            acc <= csum_add(acc, RX_Data);
            cnt <= cnt_nxt;
            if (cnt_nxt == Pkt_Len) begin
              state <= CSUM;
            end
          end else if (tmo_hit) begin
            tmo      <= '0;
            Err_Sig  <= 1'b1;
            Err_Code <= ERR_TMO;
            state    <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        CSUM: begin
          if (RX_Done_Sig) begin
            tmo <= '0;
            if (RX_Data == acc) begin
              Pkt_Valid <= 1'b1;
              RX_En_Sig <= 1'b0;
              state     <= HOLD;
            end else begin
              Err_Sig  <= 1'b1;
              Err_Code <= ERR_CSUM;
              state    <= IDLE;
            end
          end else if (tmo_hit) begin
            tmo      <= '0;
            Err_Sig  <= 1'b1;
            Err_Code <= ERR_TMO;
            state    <= IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end

        HOLD: begin
          // Incoming bytes are ignored; only the host acknowledge releases the packet.
          tmo <= '0;
          if (Pkt_Ack) begin
            Pkt_Valid <= 1'b0;
            RX_En_Sig <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_packet_parser.sv
module tb_rx_packet_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 64;
  localparam int LW      = 5;
  localparam int AW      = 4;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          done      = 1'b0;
  logic [7:0]    data      = 8'd0;
  logic [AW-1:0] rd_addr   = '0;
  logic          ack       = 1'b0;
  logic          rx_en;
  logic          pkt_valid;
  logic [LW-1:0] pkt_len;
  logic [7:0]    rd_data;
  logic          err_sig;
  logic [1:0]    err_code;

  int         n_checks   = 0;
  int         n_pass     = 0;
  int         err_hi     = 0;
  int         exp_pulses = 0;
  logic [1:0] exp_code   = 2'd0;

  rx_packet_parser #(
    .HDR_BYTE    (8'hAA),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK         (clk),
    .RSTn        (rstn),
    .RX_Done_Sig (done),
    .RX_Data     (data),
    .RX_En_Sig   (rx_en),
    .Pkt_Valid   (pkt_valid),
    .Pkt_Len     (pkt_len),
    .Rd_Addr     (rd_addr),
    .Rd_Data     (rd_data),
    .Pkt_Ack     (ack),
    .Err_Sig     (err_sig),
    .Err_Code    (err_code)
  );

  always #5 clk = ~clk;

  // Every cycle with Err_Sig high; each rejection must contribute exactly one.
  always @(negedge clk) begin
    if (err_sig === 1'b1) err_hi++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle RX_Done_Sig pulse, then gap idle cycles; returns just after the sampling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1;
    done = 1'b1;
    data = b;
    @(posedge clk);
    #1;
    done = 1'b0;
    data = $urandom_range(0, 255);
    repeat (gap) tick();
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1;
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
  endtask

  task automatic read_chk(input int a, input logic [7:0] e);
    rd_addr = AW'(a);
    tick();
    check("rd_data", rd_data, e);
  endtask

  task automatic check_reset_vals();
    check("rst_rx_en", rx_en, 1);
    check("rst_valid", pkt_valid, 0);
    check("rst_len", pkt_len, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_err_sig", err_sig, 0);
    check("rst_err_code", err_code, 0);
  endtask

  // Reference model: decides the packet's fate from the framing rules, then checks the DUT.
  task automatic run_pkt(input logic [7:0] len, input logic [7:0] pl[$], input logic [7:0] cs,
                         input int gap, input bit ack_mid);
    logic [7:0] s;
    bit         ok;
    ok = 1'b0;
    send_byte(8'hAA, gap);
    send_byte(len, gap);
    if ((len == 8'd0) || (len > MAX_LEN)) begin
      exp_code = 2'd2;
      exp_pulses++;
    end else begin
      s = len;
      foreach (pl[i]) begin
        send_byte(pl[i], gap);
        s = s + pl[i];
        if (ack_mid && (i == 0)) pulse_ack();
      end
      check("valid_before_csum", pkt_valid, 0);
      send_byte(cs, 0);
      ok = (s == cs);
      if (!ok) begin
        exp_code = 2'd1;
        exp_pulses++;
      end
    end
    check("valid_after_last", pkt_valid, ok);
    check("rx_en_after_last", rx_en, !ok);
    tick();
    tick();
    check("err_cycles", err_hi, exp_pulses);
    check("err_code", err_code, exp_code);
    if (ok) begin
      check("pkt_len", pkt_len, len);
      foreach (pl[i]) read_chk(i, pl[i]);
      send_byte(8'hAA, 0);
      send_byte(~pl[0], 0);
      read_chk(0, pl[0]);
      check("hold_valid", pkt_valid, 1);
      check("hold_rx_en", rx_en, 0);
      pulse_ack();
      check("ack_valid", pkt_valid, 0);
      check("ack_rx_en", rx_en, 1);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] len;
    logic [7:0] s;
    logic [7:0] cs;
    logic [7:0] g;

    // Reset state
    repeat (3) tick();
    check_reset_vals();
    rstn = 1'b1;
    tick();

    // Basic good packet, Pkt_Ack mid-payload must be ignored
    q = {8'h11, 8'h22, 8'h33};
    run_pkt(8'd3, q, 8'h69, 0, 1'b1);

    // Bad checksum, then the same packet correct
    run_pkt(8'd3, q, 8'h68, 0, 1'b0);
    check("csum_code", err_code, 1);
    run_pkt(8'd3, q, 8'h69, 1, 1'b0);

    // Length zero and length above MAX_LEN
    q = {};
    run_pkt(8'd0, q, 8'h00, 0, 1'b0);
    run_pkt(8'd17, q, 8'h00, 0, 1'b0);
    check("len_code", err_code, 2);

    // Timeout after AA 02 11 with no further bytes
    send_byte(8'hAA, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    repeat (TMO - 1) tick();
    check("tmo_not_early", err_sig, 0);
    tick();
    exp_pulses++;
    exp_code = 2'd3;
    check("tmo_pulse", err_sig, 1);
    check("tmo_code", err_code, 3);
    tick();
    check("tmo_pulse_one_cycle", err_sig, 0);

    // A byte on the expiry cycle wins over the timeout
    send_byte(8'hAA, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    repeat (TMO - 2) tick();
    send_byte(8'h22, 0);
    send_byte(8'h35, 0);
    check("race_valid", pkt_valid, 1);
    tick();
    tick();
    check("race_err_cycles", err_hi, exp_pulses);
    check("race_code_kept", err_code, 3);
    read_chk(1, 8'h22);
    pulse_ack();

    // Leading garbage and a stray ack in IDLE, then a one-byte packet
    pulse_ack();
    send_byte(8'h55, 0);
    send_byte(8'h00, 0);
    q = {8'h7E};
    run_pkt(8'd1, q, 8'h7F, 0, 1'b0);

    // Reset in the middle of a payload
    send_byte(8'hAA, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    rstn = 1'b0;
    #1;
    check_reset_vals();
    tick();
    rstn = 1'b1;
    exp_code = 2'd0;
    tick();
    q = {8'h05};
    run_pkt(8'd1, q, 8'h06, 0, 1'b0);

    // Randomized packets with garbage, bad lengths and corrupted checksums
    for (int n = 0; n < 30; n++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hAA) g = 8'h55;
        send_byte(g, $urandom_range(0, 2));
      end
      q = {};
      case ($urandom_range(0, 5))
        0:       len = 8'd0;
        1:       len = 8'($urandom_range(MAX_LEN + 1, 255));
        default: len = 8'($urandom_range(1, MAX_LEN));
      endcase
      s = len;
      if (len <= MAX_LEN) begin
        for (int i = 0; i < int'(len); i++) begin
          q.push_back(8'($urandom_range(0, 255)));
          s = s + q[i];
        end
      end
      cs = s;
      if ($urandom_range(0, 3) == 0) cs = s ^ 8'($urandom_range(1, 255));
      run_pkt(len, q, cs, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_packet_parser.md
Name: rx_packet_parser

Overview:
- Consumes the byte stream from the UART receive controller (`RX_Data` plus the one-cycle `RX_Done_Sig` pulse).
- Frames bytes into packets of the form: header, length, payload, checksum.
- Validates each packet and holds accepted payloads in a local buffer for a host-side reader.
- Drives the receiver's `RX_En_Sig`, so the receiver is stalled while a packet is held.

Parameters:
- HDR_BYTE, 8'hAA, start-of-packet marker byte.
- MAX_LEN, 16, maximum payload length in bytes (1..255).
- TIMEOUT_CYC, 500000, inter-byte timeout in CLK cycles while a packet is in progress.
- LW, $clog2(MAX_LEN+1), width of Pkt_Len (5 at default).
- AW, $clog2(MAX_LEN), width of Rd_Addr (4 at default).

Ports:
- CLK  input  1  system clock
- RSTn  input  1  asynchronous, active-low reset
- RX_Done_Sig  input  1  one-cycle pulse: RX_Data holds a new byte
- RX_Data  input  8  received byte, stable while RX_Done_Sig is high
- RX_En_Sig  output  1  enable to the receive controller; low while a packet is held
- Pkt_Valid  output  1  validated packet available in the buffer
- Pkt_Len  output  LW  payload length of the held packet
- Rd_Addr  input  AW  payload buffer read address
- Rd_Data  output  8  buffer[Rd_Addr], registered
- Pkt_Ack  input  1  one-cycle pulse: host has finished with the packet
- Err_Sig  output  1  one-cycle pulse when a packet is rejected
- Err_Code  output  2  0 none, 1 checksum, 2 bad length, 3 timeout; holds the last error

Behaviour:
- Reset values:
  - RX_En_Sig=1.
  - Pkt_Valid=0, Pkt_Len=0, Rd_Data=0, Err_Sig=0, Err_Code=0.
  - State=IDLE, checksum accumulator=0, byte counter=0, timeout counter=0.
- Reset is asynchronous and may arrive in any state, including mid-payload. It aborts the packet with no error pulse; buffer contents become don't-care.
- Checksum rule: 8-bit modulo-256 sum of the length byte and all payload bytes; carries are dropped.
- States and transitions:
  - IDLE:
    - RX_Done_Sig with RX_Data==HDR_BYTE -> LEN.
    - Any other byte is discarded silently, with no error.
  - LEN, on RX_Done_Sig:
    - Byte is 0 or >MAX_LEN -> Err_Code=2, Err_Sig pulse, go to IDLE.
    - Otherwise latch Pkt_Len and the length-so-far counter, set acc=byte, go to PAYLOAD.
  - PAYLOAD, on RX_Done_Sig:
    - Write the byte to buffer[cnt], add it to acc, increment cnt.
    - When cnt reaches Pkt_Len (i.e. after the last payload byte) -> CSUM.
  - CSUM, on RX_Done_Sig:
    - Byte==acc -> HOLD; Pkt_Valid rises on the cycle after the checksum pulse.
    - Byte!=acc -> Err_Code=1, Err_Sig pulse, go to IDLE.
  - HOLD:
    - Pkt_Valid=1 and RX_En_Sig=0.
    - Buffer and Pkt_Len are frozen; RX_Done_Sig is ignored.
    - Pkt_Ack -> IDLE the next cycle, with Pkt_Valid=0 and RX_En_Sig=1.
    - Pkt_Ack in any other state is ignored.
- A header byte seen in LEN/PAYLOAD/CSUM is treated as ordinary data; there is no resynchronisation.
- Timeout:
  - The counter runs in LEN, PAYLOAD and CSUM, and clears on every RX_Done_Sig and on state entry.
  - Reaching TIMEOUT_CYC-1 -> Err_Code=3, Err_Sig pulse, go to IDLE.
  - If RX_Done_Sig arrives in the same cycle as the timeout, the byte wins and no timeout occurs.
- Err_Sig is high for exactly one cycle per rejected packet. Err_Code keeps its value until the next error; it is not cleared by a good packet.
- Rd_Data: 1-cycle latency from Rd_Addr and valid in any state. Addresses >= Pkt_Len return stale contents. Buffer writes are never visible to the reader in HOLD.

Decomposition:
- Shared package rx_pkt_pkg:
  - State encoding: IDLE, LEN, PAYLOAD, CSUM, HOLD.
  - Error code constants: ERR_NONE, ERR_CSUM, ERR_LEN, ERR_TMO.
  - Default HDR_BYTE.
- One sub-module, rx_pkt_buffer: MAX_LEN x 8 register file with one synchronous write port, one registered read port, and no reset on the storage array.

Test Plan:
- Bytes AA 03 11 22 33 69 -> Pkt_Valid=1, Pkt_Len=3, Rd_Addr 0/1/2 reads 11/22/33 one cycle later, RX_En_Sig=0, Err_Sig never asserted.
- Same packet with checksum 68 -> single Err_Sig pulse, Err_Code=1, Pkt_Valid stays 0; a following correct packet is accepted.
- AA 00, then separately AA 11 (17 > MAX_LEN) -> two Err_Sig pulses, Err_Code=2; state returns to IDLE after each.
- AA 02 11, then no bytes for TIMEOUT_CYC cycles -> Err_Code=3 pulse; a byte arriving exactly on the expiry cycle instead prevents the timeout.
- Leading garbage 55 00 AA (header) 01 7E 7F -> packet accepted with payload 7E. Hold it, pulse Pkt_Ack -> next cycle Pkt_Valid=0 and RX_En_Sig=1; RX_Done_Sig pulses during HOLD do not alter the buffer.
- Assert RSTn low mid-payload (after AA 04 01 02) -> all outputs at reset values; next packet AA 01 05 06 is accepted.
